// File: rtl/div_issue_if.sv
// Operand, divider and result signals of the div_issue stage.
// The master side is the surrounding datapath (producer, divider, consumer).
interface div_issue_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] div_in1;
    logic [WIDTH-1:0] div_in2;
    logic [WIDTH-1:0] div_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             res_dbz;
    logic [7:0]       dbz_cnt;

    modport master (
        output in_valid, in_a, in_b, div_out, res_ready,
        input  in_ready, div_in1, div_in2, res_valid, res_q, res_r, res_dbz, dbz_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, div_out, res_ready,
        output in_ready, div_in1, div_in2, res_valid, res_q, res_r, res_dbz, dbz_cnt
    );
endinterface

// File: rtl/div_issue.sv
// Operand FIFO feeding a combinational divider, with a registered result slot
// holding quotient, locally computed remainder and divide-by-zero flag.
module div_issue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    div_issue_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_in_ready;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_q;
    logic [WIDTH-1:0] r_res_r;
    logic             r_res_dbz;
    logic [7:0]       r_dbz_cnt;

    logic             w_empty;
    logic             w_push;
    logic             w_fire;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_r;
    logic [CW-1:0]    w_count_nxt;

    always_comb begin
        w_empty  = (r_count == '0);
        w_head_a = w_empty ? '0 : r_mem_a[r_rd_ptr];
        w_head_b = w_empty ? '0 : r_mem_b[r_rd_ptr];
        w_push   = bus.in_valid && r_in_ready;
        w_fire   = !w_empty && (!r_res_valid || bus.res_ready);
        w_b_zero = (w_head_b == '0);
        // q*b never exceeds a, so a WIDTH-bit product is exact
        w_q      = w_b_zero ? '1 : bus.div_out;
        w_prod   = w_q * w_head_b;
        w_r      = w_b_zero ? w_head_a : w_head_a - w_prod;
        w_count_nxt = r_count;
        if (w_push && !w_fire)
            w_count_nxt = r_count + CW'(1);
        else if (w_fire && !w_push)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.in_a;
            r_mem_b[r_wr_ptr] <= bus.in_b;
        end
    end

    // Stage boundary: FIFO control and result slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_q     <= '0;
            r_res_r     <= '0;
            r_res_dbz   <= 1'b0;
            r_dbz_cnt   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_fire)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != CW'(DEPTH));
            if (w_fire) begin
                r_res_valid <= 1'b1;
                r_res_q     <= w_q;
                r_res_r     <= w_r;
                r_res_dbz   <= w_b_zero;
                if (w_b_zero)
                    r_dbz_cnt <= sat_inc8(r_dbz_cnt);
            end else if (bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.div_in1   = w_head_a;
    assign bus.div_in2   = w_head_b;
    assign bus.res_valid = r_res_valid;
    assign bus.res_q     = r_res_q;
    assign bus.res_r     = r_res_r;
    assign bus.res_dbz   = r_res_dbz;
    assign bus.dbz_cnt   = r_dbz_cnt;
endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a behavioural divider on div_in1/div_in2.
module tb_div_issue;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    div_issue_if #(.WIDTH(4)) bus ();

    div_issue #(.WIDTH(4), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Divider stand-in; returns junk on zero divisor, which the DUT must ignore
    always_comb bus.div_out = (bus.div_in2 != 4'd0) ? bus.div_in1 / bus.div_in2 : 4'h5;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [3:0] q, input logic [3:0] r, input logic d);
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_q"},     32'(bus.res_q),     32'(q));
        check({tag, "_r"},     32'(bus.res_r),     32'(r));
        check({tag, "_dbz"},   32'(bus.res_dbz),   32'(d));
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_q",     32'(bus.res_q),     32'd0);
        check("rst_res_r",     32'(bus.res_r),     32'd0);
        check("rst_res_dbz",   32'(bus.res_dbz),   32'd0);
        check("rst_dbz_cnt",   32'(bus.dbz_cnt),   32'd0);
        check("rst_div_in1",   32'(bus.div_in1),   32'd0);
        check("rst_div_in2",   32'(bus.div_in2),   32'd0);

        // Single op 13/4
        bus.res_ready = 1'b1;
        push(4'd13, 4'd4);
        step();
        bus.in_valid = 1'b0;
        check("single_noval", 32'(bus.res_valid), 32'd0);
        check("single_din1",  32'(bus.div_in1),   32'd13);
        check("single_din2",  32'(bus.div_in2),   32'd4);
        step();
        chk_res("single", 4'd3, 4'd1, 1'b0);
        step();
        check("single_drain", 32'(bus.res_valid), 32'd0);

        // Streaming, one per cycle
        push(4'd7, 4'd2);
        step();
        push(4'd15, 4'd5);
        step();
        chk_res("str0", 4'd3, 4'd1, 1'b0);
        check("str0_rdy", 32'(bus.in_ready), 32'd1);
        push(4'd9, 4'd3);
        step();
        chk_res("str1", 4'd3, 4'd0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        chk_res("str2", 4'd3, 4'd0, 1'b0);
        step();
        check("str_drain", 32'(bus.res_valid), 32'd0);

        // Backpressure: four offered, three accepted
        bus.res_ready = 1'b0;
        push(4'd8, 4'd3);
        step();
        push(4'd11, 4'd2);
        step();
        chk_res("bp0", 4'd2, 4'd2, 1'b0);
        check("bp_rdy1", 32'(bus.in_ready), 32'd1);
        push(4'd6, 4'd6);
        step();
        check("bp_full", 32'(bus.in_ready), 32'd0);
        push(4'd14, 4'd7);
        step();
        check("bp_full2", 32'(bus.in_ready), 32'd0);
        chk_res("bp_hold", 4'd2, 4'd2, 1'b0);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        step();
        chk_res("bp1", 4'd5, 4'd1, 1'b0);
        check("bp_rdy2", 32'(bus.in_ready), 32'd1);
        step();
        chk_res("bp2", 4'd1, 4'd0, 1'b0);
        step();
        check("bp_drain", 32'(bus.res_valid), 32'd0);
        step();
        check("bp_no4th", 32'(bus.res_valid), 32'd0);

        // Boundary operands: zero dividend, divisor of one
        push(4'd0, 4'd5);
        step();
        push(4'd15, 4'd1);
        step();
        chk_res("zero_a", 4'd0, 4'd0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        chk_res("div_one", 4'd15, 4'd0, 1'b0);
        step();

        // Divide by zero and counter saturation
        push(4'd9, 4'd0);
        step();
        bus.in_valid = 1'b0;
        step();
        chk_res("dbz", 4'd15, 4'd9, 1'b1);
        check("dbz_cnt1", 32'(bus.dbz_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            push(4'(i), 4'd0);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        check("dbz_sat", 32'(bus.dbz_cnt), 32'd255);

        // Reset with two queued entries and a held result
        bus.res_ready = 1'b0;
        push(4'd5, 4'd2);
        step();
        push(4'd7, 4'd7);
        step();
        push(4'd3, 4'd1);
        step();
        chk_res("pre_rst", 4'd2, 4'd1, 1'b0);
        check("pre_rst_full", 32'(bus.in_ready), 32'd0);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready),  32'd1);
        check("mid_rst_cnt",   32'(bus.dbz_cnt),   32'd0);
        check("mid_rst_din1",  32'(bus.div_in1),   32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_stale", 32'(bus.res_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
